ex_md_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline: ALU plus a multi-cycle multiply/divide unit with HI/LO registers, and the E→M pipeline register. Consumes decoded, already-forwarded operands from the D→E register. Produces the `Instr_M`, `ALUOut_M`, `PC_M`, `WData_M` and `WReg_M` bundle consumed by the data-memory stage. Raises `md_stall` so the hazard unit can freeze F/D/E while HI/LO is busy.

---
 rtl/ex_md_stage.sv | 155 +++++++++++++++
 tb/tb_ex_md_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_md_stage.sv
// rtl/ex_md_stage.sv - MIPS execute stage: ALU, optional HI/LO multiply/divide unit (MD_UNIT_EN), E->M register
module ex_md_stage #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] Instr_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] RS_E,
    input  logic [31:0] RT_E,
    input  logic [31:0] Imm32_E,
    input  logic [4:0]  WReg_E,
    output logic [31:0] Instr_M,
    output logic [31:0] ALUOut_M,
    output logic [31:0] PC_M,
    output logic [31:0] WData_M,
    output logic [4:0]  WReg_M,
    output logic        md_busy,
    output logic        md_stall
);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  shamt;
    logic        is_r;
    logic [31:0] alu_res;
    logic [31:0] result;

    assign op    = Instr_E[31:26];
    assign fn    = Instr_E[5:0];
    assign shamt = Instr_E[10:6];
    assign is_r  = (op == 6'h00);

    always_comb begin
        alu_res = '0;
        if (is_r) begin
            case (fn)
                6'h21:   alu_res = RS_E + RT_E;
                6'h23:   alu_res = RS_E - RT_E;
                6'h24:   alu_res = RS_E & RT_E;
                6'h25:   alu_res = RS_E | RT_E;
                6'h2a:   alu_res = {31'b0, $signed(RS_E) < $signed(RT_E)};
                6'h00:   alu_res = RT_E << shamt;
                default: alu_res = '0;
            endcase
        end else begin
            case (op)
                6'h0d:                      alu_res = RS_E | Imm32_E;
                6'h0f:                      alu_res = {Imm32_E[15:0], 16'h0000};
                6'h23, 6'h2b, 6'h20, 6'h28: alu_res = RS_E + Imm32_E;
                default:                    alu_res = '0;
            endcase
        end
    end

`ifdef MD_UNIT_EN
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             op_div;
    logic             op_signed;
    logic [63:0]      prod;
    logic [31:0]      quot;
    logic [31:0]      rem;
    logic             is_muldiv;
    logic             is_md;
    logic             md_start;

    assign is_muldiv = is_r && (fn[5:2] == 4'b0110);
    assign is_md     = is_muldiv || (is_r && (fn[5:2] == 4'b0100));
    assign md_busy   = (cnt != '0);
    assign md_stall  = is_md && md_busy;
    assign md_start  = is_muldiv && !md_stall;

    // Signed and unsigned products share one 64x64 multiplier via conditional sign extension.
    always_comb begin
        prod = {{32{op_signed & op_a[31]}}, op_a} * {{32{op_signed & op_b[31]}}, op_b};
        if (op_signed) begin
            quot = $signed(op_a) / $signed(op_b);
            rem  = $signed(op_a) % $signed(op_b);
        end else begin
            quot = op_a / op_b;
            rem  = op_a % op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
        end else if (md_start) begin
            cnt       <= fn[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            op_a      <= RS_E;
            op_b      <= RT_E;
            op_div    <= fn[1];
            op_signed <= !fn[0];
        end else if (md_busy) begin
            cnt <= cnt - 1'b1;
            // Divide by zero still burns the full latency but leaves HI/LO intact.
            if (cnt == CNT_W'(1)) begin
                if (!op_div) begin
                    hi <= prod[63:32];
                    lo <= prod[31:0];
                end else if (op_b != '0) begin
                    hi <= rem;
                    lo <= quot;
                end
            end
        end else if (is_r && fn == 6'h11) begin
            hi <= RS_E;
        end else if (is_r && fn == 6'h13) begin
            lo <= RS_E;
        end
    end

    always_comb begin
        result = alu_res;
        if (is_r && fn == 6'h10) result = hi;
        if (is_r && fn == 6'h12) result = lo;
    end
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(MULT_CYCLES + DIV_CYCLES);
    assign md_busy    = 1'b0;
    assign md_stall   = 1'b0;
    assign result     = alu_res;
`endif

    // A stalled instruction leaves a bubble (sll $0,$0,0) behind in M.
    always_ff @(posedge clk) begin
        if (clr || md_stall) begin
            Instr_M  <= '0;
            ALUOut_M <= '0;
            PC_M     <= '0;
            WData_M  <= '0;
            WReg_M   <= '0;
        end else begin
            Instr_M  <= Instr_E;
            ALUOut_M <= result;
            PC_M     <= PC_E;
            WData_M  <= RT_E;
            WReg_M   <= WReg_E;
        end
    end
endmodule

// File: tb/tb_ex_md_stage.sv
// tb/tb_ex_md_stage.sv - scoreboard bench for ex_md_stage against a behavioural model
module tb_ex_md_stage;
    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MD_UNIT_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] instr_e = '0, pc_e = '0, rs_e = '0, rt_e = '0, imm_e = '0;
    logic [4:0]  wreg_e = '0;
    logic [31:0] instr_m, aluout_m, pc_m, wdata_m;
    logic [4:0]  wreg_m;
    logic        md_busy, md_stall;

    ex_md_stage #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .clr(clr), .Instr_E(instr_e), .PC_E(pc_e), .RS_E(rs_e), .RT_E(rt_e),
        .Imm32_E(imm_e), .WReg_E(wreg_e), .Instr_M(instr_m), .ALUOut_M(aluout_m),
        .PC_M(pc_m), .WData_M(wdata_m), .WReg_M(wreg_m), .md_busy(md_busy), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: architectural HI/LO, a pending result and the cycle at which it lands.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          m_pend = 1'b0;
    int          m_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] sh);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] o, input logic [15:0] imm);
        return {o, 5'd1, 5'd2, imm};
    endfunction

    task automatic md_begin(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] ma, mb, qq, rr;
        bit na, nb;
        m_done = cyc + 1 + (f[1] ? DC : MC);
        m_pend = 1'b1;
        if (f == 6'h18) begin
            p = 64'($signed(a)) * 64'($signed(b));
            p_hi = p[63:32]; p_lo = p[31:0];
        end else if (f == 6'h19) begin
            p = {32'h0, a} * {32'h0, b};
            p_hi = p[63:32]; p_lo = p[31:0];
        end else if (b == 0) begin
            m_pend = 1'b0;
        end else if (f == 6'h1a) begin
            na = a[31]; nb = b[31];
            ma = na ? -a : a;
            mb = nb ? -b : b;
            qq = ma / mb;
            rr = ma % mb;
            p_lo = (na ^ nb) ? -qq : qq;
            p_hi = na ? -rr : rr;
        end else begin
            p_lo = a / b;
            p_hi = a % b;
        end
    endtask

    task automatic model_step(output bit stall, output exp_t e);
        logic [5:0] o, f;
        bit busy, md;
        o = instr_e[31:26];
        f = instr_e[5:0];
        if (m_pend && cyc >= m_done) begin
            m_hi = p_hi; m_lo = p_lo; m_pend = 1'b0;
        end
        busy  = MD_EN && (cyc < m_done);
        md    = MD_EN && (o == 0) && (f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b});
        stall = md && busy;
        e = '0;
        if (clr) begin
            m_hi = '0; m_lo = '0; m_pend = 1'b0; m_done = 0;
        end else if (!stall) begin
            e.instr = instr_e; e.pc = pc_e; e.wdata = rt_e; e.wreg = wreg_e;
            if (o == 0) begin
                case (f)
                    6'h21: e.alu = rs_e + rt_e;
                    6'h23: e.alu = rs_e - rt_e;
                    6'h24: e.alu = rs_e & rt_e;
                    6'h25: e.alu = rs_e | rt_e;
                    6'h2a: e.alu = ($signed(rs_e) < $signed(rt_e)) ? 32'd1 : 32'd0;
                    6'h00: e.alu = rt_e << instr_e[10:6];
                    6'h10: if (MD_EN) e.alu = m_hi;
                    6'h12: if (MD_EN) e.alu = m_lo;
                    6'h11: if (MD_EN) m_hi = rs_e;
                    6'h13: if (MD_EN) m_lo = rs_e;
                    6'h18, 6'h19, 6'h1a, 6'h1b: if (MD_EN) md_begin(f, rs_e, rt_e);
                    default: ;
                endcase
            end else begin
                case (o)
                    6'h0d: e.alu = rs_e | imm_e;
                    6'h0f: e.alu = {imm_e[15:0], 16'h0000};
                    6'h23, 6'h2b, 6'h20, 6'h28: e.alu = rs_e + imm_e;
                    default: ;
                endcase
            end
        end
        e.busy = MD_EN && ((cyc + 1) < m_done);
    endtask

    // Hazard unit stand-in: holds the instruction in E while md_stall is up.
    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] wr, input bit c);
        bit st;
        exp_t e;
        int n = 0;
        do begin
            @(negedge clk);
            instr_e = ins; rs_e = rs; rt_e = rt; imm_e = imm; wreg_e = wr; clr = c;
            pc_e = 32'h0040_0000 + 32'(cyc * 4);
            #1;
            model_step(st, e);
            chk("md_stall", {31'b0, md_stall}, {31'b0, st});
            q.push_back(e);
            n++;
        end while (st && !c && n < 64);
        chk("stall_bound", (n < 64) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("instr_m", instr_m, e.instr);
                chk("aluout_m", aluout_m, e.alu);
                chk("pc_m", pc_m, e.pc);
                chk("wdata_m", wdata_m, e.wdata);
                chk("wreg_m", {27'b0, wreg_m}, {27'b0, e.wreg});
                chk("md_busy", {31'b0, md_busy}, {31'b0, e.busy});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] ops [20];

    initial begin : driver
        logic [31:0] a, b, imm;
        int k;
        ops[0]  = r_ins(6'h21, 5'd0); ops[1]  = r_ins(6'h23, 5'd0);
        ops[2]  = r_ins(6'h24, 5'd0); ops[3]  = r_ins(6'h25, 5'd0);
        ops[4]  = r_ins(6'h2a, 5'd0); ops[5]  = r_ins(6'h00, 5'd7);
        ops[6]  = i_ins(6'h0d, 16'h0); ops[7]  = i_ins(6'h0f, 16'h0);
        ops[8]  = i_ins(6'h23, 16'h0); ops[9]  = i_ins(6'h2b, 16'h0);
        ops[10] = i_ins(6'h20, 16'h0); ops[11] = i_ins(6'h28, 16'h0);
        ops[12] = r_ins(6'h18, 5'd0); ops[13] = r_ins(6'h19, 5'd0);
        ops[14] = r_ins(6'h1a, 5'd0); ops[15] = r_ins(6'h1b, 5'd0);
        ops[16] = r_ins(6'h10, 5'd0); ops[17] = r_ins(6'h12, 5'd0);
        ops[18] = r_ins(6'h11, 5'd0); ops[19] = r_ins(6'h13, 5'd0);

        // Reset with traffic present, then directed cases.
        issue(ops[0], 32'h1234, 32'h5678, 32'h9, 5'd3, 1'b1);
        issue(ops[0], 32'hFFFF_FFFF, 32'd2, 32'h0, 5'd3, 1'b0);
        issue(ops[9], 32'h10, 32'hAB, 32'hFFFF_FFFC, 5'd0, 1'b0);
        issue(ops[12], -32'sd3, 32'd7, 32'h0, 5'd0, 1'b0);
        issue(ops[17], 32'h0, 32'h0, 32'h0, 5'd4, 1'b0);
        issue(ops[16], 32'h0, 32'h0, 32'h0, 5'd5, 1'b0);
        issue(ops[14], -32'sd7, 32'd2, 32'h0, 5'd0, 1'b0);
        issue(ops[17], 32'h0, 32'h0, 32'h0, 5'd4, 1'b0);
        issue(ops[16], 32'h0, 32'h0, 32'h0, 5'd5, 1'b0);
        issue(ops[15], 32'd99, 32'd0, 32'h0, 5'd0, 1'b0);
        issue(ops[17], 32'h0, 32'h0, 32'h0, 5'd4, 1'b0);
        issue(ops[16], 32'h0, 32'h0, 32'h0, 5'd5, 1'b0);
        issue(ops[13], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd0, 1'b0);
        issue(ops[0], 32'd5, 32'd6, 32'h0, 5'd8, 1'b0);
        issue(ops[17], 32'h0, 32'h0, 32'h0, 5'd4, 1'b0);
        // Reset on the third busy cycle of a mult.
        issue(ops[12], 32'd1000, 32'd1000, 32'h0, 5'd0, 1'b0);
        issue(ops[0], 32'd1, 32'd1, 32'h0, 5'd9, 1'b0);
        issue(ops[1], 32'd9, 32'd1, 32'h0, 5'd9, 1'b0);
        issue(ops[0], 32'd2, 32'd2, 32'h0, 5'd9, 1'b1);
        issue(ops[17], 32'h0, 32'h0, 32'h0, 5'd4, 1'b0);
        issue(ops[16], 32'h0, 32'h0, 32'h0, 5'd5, 1'b0);

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 19);
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 20) - 10;
                b = $urandom_range(0, 8) - 4;
            end else begin
                a = $urandom;
                b = $urandom;
            end
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            imm = $urandom;
            issue(ops[k] | {21'b0, 5'($urandom), 6'b0} & ((k == 5) ? 32'h7C0 : 32'h0) | ((k >= 6 && k <= 11) ? {16'b0, imm[15:0]} : 32'h0),
                  a, b, imm, 5'($urandom), ($urandom_range(0, 59) == 0));
        end

        @(posedge clk);
        #2;
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
